// File: rtl/nano_line_mem_ctrl_pkg.sv
// nano_mem_pkg: shared types and constants for the nano line memory controller
package nano_mem_pkg;
    localparam int LINE_WORDS = 8;
    localparam int BEAT_W = 3;
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_RD_WAIT, ST_RESP, ST_WR} state_e;
    typedef enum logic {PORT_INSTR, PORT_DATA} port_e;
    typedef logic [LINE_WORDS-1:0][31:0] line_t;
endpackage

// File: rtl/nano_line_mem_ctrl_if.sv
// nano_line_mem_ctrl_if: cache-side instruction and data line channels
interface nano_line_mem_ctrl_if;
    import nano_mem_pkg::*;
    logic        rden_instr;
    logic [31:0] addr_instr;
    logic        gnt_instr;
    logic        rvalid_instr;
    line_t       rdata_instr;
    logic        rden_data;
    logic        wren_data;
    logic [31:0] addr_data;
    line_t       wdata_data;
    logic        gnt_data;
    logic        rvalid_data;
    line_t       rdata_data;
    modport master (
        output rden_instr, addr_instr, rden_data, wren_data, addr_data, wdata_data,
        input  gnt_instr, rvalid_instr, rdata_instr, gnt_data, rvalid_data, rdata_data
    );
    modport slave (
        input  rden_instr, addr_instr, rden_data, wren_data, addr_data, wdata_data,
        output gnt_instr, rvalid_instr, rdata_instr, gnt_data, rvalid_data, rdata_data
    );
endinterface

// File: rtl/nano_line_mem_ctrl_rr_arb2.sv
// nano_rr_arb2: two-requester round-robin arbiter, pointer advances only on an accepted grant
module nano_rr_arb2
    import nano_mem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_vld,
    output port_e      o_sel
);
    port_e last_q, last_d;
    // serve the sole requester, or the side not served last when both ask
    always_comb begin
        o_vld = |i_req;
        o_sel = &i_req ? (last_q == PORT_INSTR ? PORT_DATA : PORT_INSTR)
                       : (i_req[0] ? PORT_INSTR : PORT_DATA);
        last_d = i_take ? o_sel : last_q;
    end
    // last-served pointer; starting at data makes instr win the first tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last_q <= PORT_DATA;
        else last_q <= last_d;
    end
endmodule

// File: rtl/nano_line_mem_ctrl.sv
// nano_line_mem_ctrl: serialises instr/data 256-bit line requests onto a 32-bit single-port SRAM
module nano_line_mem_ctrl
    import nano_mem_pkg::*;
#(
    parameter int SRAM_AW = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    nano_line_mem_ctrl_if.slave  mm,
    output logic                 o_sram_en,
    output logic                 o_sram_we,
    output logic [SRAM_AW-1:0]   o_sram_addr,
    output logic [31:0]          o_sram_wdata,
    input  logic [31:0]          i_sram_rdata
);
    localparam int LW = SRAM_AW - BEAT_W;
    state_e            state_q, state_d;
    port_e             port_q, port_d, arb_sel;
    logic [BEAT_W-1:0] cnt_q, cnt_d, cap_idx_q, cap_idx_d;
    logic [LW-1:0]     base_q, base_d;
    line_t             wline_q, wline_d, line_q, line_d;
    logic              gnt_i_q, gnt_i_d, gnt_d_q, gnt_d_d, cap_q, cap_d;
    logic              arb_vld, take;

    nano_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({mm.rden_data | mm.wren_data, mm.rden_instr}),
        .i_take  (take),
        .o_vld   (arb_vld),
        .o_sel   (arb_sel)
    );

    // control FSM: arbitrate and latch the request in IDLE, then walk the eight beats
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wline_d = wline_q;
        gnt_i_d = 1'b0;
        gnt_d_d = 1'b0;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: if (arb_vld) begin
                take   = 1'b1;
                port_d = arb_sel;
                cnt_d  = '0;
                if (arb_sel == PORT_INSTR) begin
                    base_d  = mm.addr_instr[SRAM_AW+1:5];
                    gnt_i_d = 1'b1;
                    state_d = ST_RD;
                end else begin
                    base_d  = mm.addr_data[SRAM_AW+1:5];
                    wline_d = mm.wdata_data;
                    gnt_d_d = 1'b1;
                    state_d = mm.wren_data ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? ST_RD_WAIT : ST_RD;
            end
            ST_RD_WAIT: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            ST_WR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? ST_IDLE : ST_WR;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // read data returns one cycle after its beat; remember which slot it belongs to
    always_comb begin
        cap_d     = state_q == ST_RD;
        cap_idx_d = cnt_q;
        line_d    = line_q;
        if (cap_q) line_d[cap_idx_q] = i_sram_rdata;
    end

    // state and datapath registers; reset abandons any burst in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_INSTR;
            cnt_q     <= '0;
            base_q    <= '0;
            wline_q   <= '0;
            line_q    <= '0;
            gnt_i_q   <= 1'b0;
            gnt_d_q   <= 1'b0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            wline_q   <= wline_d;
            line_q    <= line_d;
            gnt_i_q   <= gnt_i_d;
            gnt_d_q   <= gnt_d_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign o_sram_en       = state_q == ST_RD || state_q == ST_WR;
    assign o_sram_we       = state_q == ST_WR;
    assign o_sram_addr     = o_sram_en ? {base_q, cnt_q} : '0;
    assign o_sram_wdata    = o_sram_we ? wline_q[cnt_q] : '0;
    assign mm.gnt_instr    = gnt_i_q;
    assign mm.gnt_data     = gnt_d_q;
    assign mm.rvalid_instr = state_q == ST_RESP && port_q == PORT_INSTR;
    assign mm.rvalid_data  = state_q == ST_RESP && port_q == PORT_DATA;
    assign mm.rdata_instr  = line_q;
    assign mm.rdata_data   = line_q;
endmodule

// File: tb/tb_nano_line_mem_ctrl.sv
// tb_nano_line_mem_ctrl: directed and randomized checks against a transaction-level timeline model
module tb_nano_line_mem_ctrl;
    import nano_mem_pkg::*;
    localparam int AW = 14;
    localparam int NC = 6000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [NC-1:0] e_gi = '0, e_gd = '0, e_en = '0, e_we = '0, e_ri = '0, e_rd = '0;
    logic [AW-1:0] e_addr [NC];
    logic [31:0] e_wd [NC];
    line_t e_line [NC];
    logic [AW-1:0] a_log [NC];
    int cyc, free_at, nvec, nerr, t0, gnt_i_cyc, gnt_d_cyc, rv_cyc, we_beats, rvd_cnt;
    port_e last;
    line_t rv_line, lit;
    bit rand_en;

    always #5 clk = ~clk;

    nano_line_mem_ctrl_if mm();

    nano_line_mem_ctrl #(.SRAM_AW(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .mm           (mm),
        .o_sram_en    (sram_en),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    // single-port SRAM with one-cycle read latency, plus a bench preload path
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (sram_en) begin
            if (sram_we) sram[sram_addr] <= sram_wdata;
            else sram_rdata <= sram[sram_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F);
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_addr = AW'(a);
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic clear_from(input int n);
        for (int i = n; i < NC; i++) begin
            e_gi[i] = 0; e_gd[i] = 0; e_en[i] = 0; e_we[i] = 0; e_ri[i] = 0; e_rd[i] = 0;
        end
    endtask

    // model: a request visible in an idle cycle T is served as one whole line transaction
    task automatic plan();
        port_e p;
        bit wr;
        logic [31:0] a;
        logic [AW-4:0] ln;
        line_t rl;
        int w;
        if (cyc < free_at || cyc + 12 >= NC || !(mm.rden_instr || mm.rden_data || mm.wren_data)) return;
        if (mm.rden_instr && (mm.rden_data || mm.wren_data)) p = (last == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
        else p = mm.rden_instr ? PORT_INSTR : PORT_DATA;
        last = p;
        wr = (p == PORT_DATA) && mm.wren_data;
        a = (p == PORT_INSTR) ? mm.addr_instr : mm.addr_data;
        ln = a[AW+1:5];
        if (p == PORT_INSTR) e_gi[cyc+1] = 1'b1;
        else e_gd[cyc+1] = 1'b1;
        rl = '0;
        for (int k = 0; k < 8; k++) begin
            w = int'(ln) * 8 + k;
            e_en[cyc+1+k] = 1'b1;
            e_we[cyc+1+k] = wr;
            e_addr[cyc+1+k] = AW'(w);
            if (wr) begin
                e_wd[cyc+1+k] = mm.wdata_data[k];
                ref_mem[w] = mm.wdata_data[k];
            end else rl[k] = ref_mem[w];
        end
        if (wr) free_at = cyc + 9;
        else begin
            if (p == PORT_INSTR) e_ri[cyc+10] = 1'b1;
            else e_rd[cyc+10] = 1'b1;
            e_line[cyc+10] = rl;
            free_at = cyc + 11;
        end
    endtask

    task automatic rand_req();
        int op;
        if (!mm.rden_instr && !mm.gnt_instr && $urandom_range(0, 3) == 0) begin
            mm.addr_instr = rand_addr();
            mm.rden_instr = 1'b1;
        end
        if (!mm.rden_data && !mm.wren_data && !mm.gnt_data && $urandom_range(0, 3) == 0) begin
            op = $urandom_range(0, 2);
            mm.addr_data = rand_addr();
            for (int k = 0; k < 8; k++) mm.wdata_data[k] = $urandom;
            mm.rden_data = op != 1;
            mm.wren_data = op != 0;
        end
    endtask

    // one clock: compare every output with the model, then requester behaviour, then model sampling
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("gnt_instr", mm.gnt_instr, e_gi[cyc]);
        chk("gnt_data", mm.gnt_data, e_gd[cyc]);
        chk("sram_en", sram_en, e_en[cyc]);
        chk("sram_we", sram_we, e_we[cyc]);
        if (e_en[cyc]) chk("sram_addr", sram_addr, e_addr[cyc]);
        if (e_en[cyc] && e_we[cyc]) chk("sram_wdata", sram_wdata, e_wd[cyc]);
        chk("rvalid_instr", mm.rvalid_instr, e_ri[cyc]);
        chk("rvalid_data", mm.rvalid_data, e_rd[cyc]);
        if (e_ri[cyc]) chk("rdata_instr", mm.rdata_instr, e_line[cyc]);
        if (e_rd[cyc]) chk("rdata_data", mm.rdata_data, e_line[cyc]);
        a_log[cyc] = sram_addr;
        if (sram_en && sram_we) we_beats++;
        if (mm.rvalid_data) rvd_cnt++;
        if (mm.rvalid_instr || mm.rvalid_data) begin
            rv_cyc = cyc;
            rv_line = mm.rvalid_instr ? mm.rdata_instr : mm.rdata_data;
        end
        if (mm.gnt_instr) begin
            gnt_i_cyc = cyc;
            mm.rden_instr = 1'b0;
        end
        if (mm.gnt_data) begin
            gnt_d_cyc = cyc;
            mm.rden_data = 1'b0;
            mm.wren_data = 1'b0;
        end
        if (rand_en) rand_req();
        plan();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (cyc < free_at || mm.rden_instr || mm.rden_data || mm.wren_data); i++) step();
        chk("idle_timeout", cyc >= free_at && !(mm.rden_instr || mm.rden_data || mm.wren_data), 1'b1);
    endtask

    task automatic req(input bit ri, input bit rd, input bit wr, input logic [31:0] a, input line_t wl);
        mm.rden_instr = ri;
        if (ri) mm.addr_instr = a;
        mm.rden_data = rd;
        mm.wren_data = wr;
        if (rd || wr) begin
            mm.addr_data = a;
            mm.wdata_data = wl;
        end
        t0 = cyc;
        plan();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sram_en"}, sram_en, 1'b0);
        chk({tag, "_sram_we"}, sram_we, 1'b0);
        chk({tag, "_sram_addr"}, sram_addr, '0);
        chk({tag, "_sram_wdata"}, sram_wdata, '0);
        chk({tag, "_gnt"}, {mm.gnt_instr, mm.gnt_data}, '0);
        chk({tag, "_rvalid"}, {mm.rvalid_instr, mm.rvalid_data}, '0);
        chk({tag, "_rdata_instr"}, mm.rdata_instr, '0);
        chk({tag, "_rdata_data"}, mm.rdata_data, '0);
    endtask

    initial begin
        mm.rden_instr = 1'b0; mm.addr_instr = '0;
        mm.rden_data = 1'b0; mm.wren_data = 1'b0; mm.addr_data = '0; mm.wdata_data = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        nvec = 0; nerr = 0; cyc = 0; free_at = 0; last = PORT_DATA; rand_en = 1'b0;
        gnt_i_cyc = -1; gnt_d_cyc = -1; rv_cyc = -1; we_beats = 0; rvd_cnt = 0;
        for (int i = 0; i < 128; i++) preload(i, (i >= 16 && i < 24) ? 32'h100 + 32'(i - 16) : $urandom);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // instr read of line 0x40: words 16..23
        wait_idle();
        req(1, 0, 0, 32'h40, '0);
        run(11);
        for (int k = 0; k < 8; k++) lit[k] = 32'h100 + 32'(k);
        chk("t1_gnt_time", gnt_i_cyc, t0 + 1);
        chk("t1_addr_first", a_log[t0+1], 14'd16);
        chk("t1_addr_last", a_log[t0+8], 14'd23);
        chk("t1_rv_time", rv_cyc, t0 + 10);
        chk("t1_rdata", rv_line, lit);

        // data write line 0x20 then read it back
        for (int k = 0; k < 8; k++) lit[k] = 32'hA0 + 32'(k);
        wait_idle();
        req(0, 0, 1, 32'h20, lit);
        wait_idle();
        req(0, 1, 0, 32'h20, '0);
        run(11);
        chk("t2_rv_time", rv_cyc, t0 + 10);
        chk("t2_rdata", rv_line, lit);
        chk("t2_sram", {sram[15], sram[14], sram[13], sram[12], sram[11], sram[10], sram[9], sram[8]}, lit);

        // simultaneous reads: instr first, then data while instr asks again
        wait_idle();
        req(1, 1, 0, 32'h80, '0);
        run(2);
        mm.rden_instr = 1'b1;
        run(10);
        chk("t3_first_instr", gnt_i_cyc, t0 + 1);
        chk("t3_second_data", gnt_d_cyc, t0 + 12);
        wait_idle();

        // rden and wren together: write only
        wait_idle();
        for (int k = 0; k < 8; k++) lit[k] = $urandom;
        we_beats = 0;
        rvd_cnt = 0;
        req(0, 1, 1, 32'h60, lit);
        wait_idle();
        run(3);
        chk("t4_we_beats", we_beats, 8);
        chk("t4_no_rvalid", rvd_cnt, 0);

        // misaligned address with junk upper bits maps to line 0x40
        wait_idle();
        req(1, 0, 0, 32'hFFFF_005F, '0);
        run(11);
        for (int k = 0; k < 8; k++) lit[k] = 32'h100 + 32'(k);
        chk("t6_addr_first", a_log[t0+1], 14'd16);
        chk("t6_rdata", rv_line, lit);

        // reset during read beat 4
        wait_idle();
        req(1, 0, 0, 32'hA0, '0);
        run(5);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        clear_from(cyc + 1);
        free_at = NC;
        mm.rden_instr = 1'b0;
        rv_cyc = -1;
        run(3);
        rst_n = 1'b1;
        last = PORT_DATA;
        free_at = cyc + 1;
        run(15);
        chk("t5_no_rvalid", rv_cyc, -1);
        wait_idle();
        req(0, 1, 0, 32'h20, '0);
        run(11);
        for (int k = 0; k < 8; k++) lit[k] = 32'hA0 + 32'(k);
        chk("t5_gnt_time", gnt_d_cyc, t0 + 1);
        chk("t5_rdata", rv_line, lit);

        // randomized traffic over lines 0..15
        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        wait_idle();
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/nano_line_mem_ctrl.md
# nano_line_mem_ctrl

Memory-side responder for the two line-refill/write-back channels of the nano cache (instruction read-only, data read/write). It accepts 256-bit line requests, arbitrates between the two channels round-robin, and serializes each line into eight accesses on a 32-bit single-port SRAM with one-cycle read latency. It sits between the cache top and the on-chip SRAM and terminates both cache-side memory interfaces.

## Interface
- SRAM_AW, 14, SRAM word-address width (2^SRAM_AW 32-bit words)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mm_rden_instr  in  1  instr line read request, held until gnt
- i_mm_addr_instr  in  32  instr byte address; bits [4:0] ignored
- o_mm_gnt_instr  out  1  one-cycle accept pulse
- o_mm_rvalid_instr  out  1  one-cycle line-valid pulse
- o_mm_rdata_instr  out  8x32  line data, word k at index k
- i_mm_rden_data  in  1  data line read request, held until gnt
- i_mm_wren_data  in  1  data line write request, held until gnt
- i_mm_addr_data  in  32  data byte address; bits [4:0] ignored
- i_mm_wdata_data  in  8x32  write line, word k at index k
- o_mm_gnt_data  out  1  one-cycle accept pulse
- o_mm_rvalid_data  out  1  one-cycle line-valid pulse (reads only)
- o_mm_rdata_data  out  8x32  line data
- o_sram_en  out  1  SRAM access enable
- o_sram_we  out  1  SRAM write enable
- o_sram_addr  out  SRAM_AW  SRAM word address
- o_sram_wdata  out  32  SRAM write data
- i_sram_rdata  in  32  SRAM read data, valid the cycle after en with we=0

## Operation
- Line word base = addr[SRAM_AW+1:5] concatenated with 3-bit beat counter; counter wraps 7->0 only at end of line.
- States: IDLE, RD (8 issue beats), RD_WAIT (capture last word), RESP (rvalid pulse), WR (8 write beats).
- IDLE: requester set = {instr rden, data rden|wren}. One requester -> serve it; both -> serve the one not served last (rr pointer, reset value = instr preferred). Latch port id, line address, and for writes the full wdata line; go RD or WR, assert that port's gnt next cycle.
- Data port with wren=1 and rden=1 in the same cycle: wren wins, operation is a write; rden must be re-presented later (it is not served from that request).
- RD: beat k drives en=1, we=0, addr=base+k; word k captured into shared line buffer index k the next cycle. After beat 7 -> RD_WAIT -> RESP.
- RESP: rvalid of the latched port =1 for one cycle; rdata of that port = line buffer; -> IDLE. Both rdata ports are driven from the shared buffer; contents are guaranteed only in the rvalid cycle.
- WR: beat k drives en=1, we=1, addr=base+k, wdata=latched word k; after beat 7 -> IDLE; no rvalid for writes.
- Strict ordering: a read following a write to the same line returns the written data.
- Reset (any time, including mid-burst): state IDLE, counter 0, rr pointer = instr, all outputs 0, line buffer 0; an aborted burst is not resumed and no gnt/rvalid is emitted for it.

## Timing
- Request sampled in IDLE at cycle T -> gnt at T+1 (registered), first SRAM beat at T+1.
- Read: beats T+1..T+8, RD_WAIT T+9, rvalid T+10; IDLE T+11; next request sampled T+11, gnt T+12.
- Write: beats T+1..T+8, IDLE T+9; next gnt T+10 at earliest.
- Requester must hold request/addr/wdata until it sees gnt and drop it the cycle after; the block never re-samples while busy.
- Only one of o_mm_gnt_instr/o_mm_gnt_data is ever high; same for rvalids; o_sram_en high exactly 8 cycles per accepted request.

## Structure
- Package nano_mem_pkg: state enum, LINE_WORDS=8, BEAT_W=3, port-id enum {PORT_INSTR, PORT_DATA}.
- Sub-module nano_rr_arb2: 2-requester round-robin arbiter with update-on-grant pointer; rest is one FSM module.

## Test plan
- Instr read of addr 0x40 with SRAM words 16..23 = 0x100+k -> gnt T+1, sram addr 16..23 on T+1..T+8, rvalid_instr at T+10, rdata[k]=0x100+k.
- Data write addr 0x20, wdata[k]=0xA0+k, then data read 0x20 -> SRAM words 8..15 written, read returns 0xA0+k.
- Instr and data read asserted same cycle twice in a row -> first grant instr, second data (alternation), no gnt overlap.
- Data rden and wren together at addr 0x60 -> write only (we=1 all 8 beats), no rvalid_data.
- Assert i_rst_n=0 at read beat 4 -> all outputs 0 immediately, no rvalid after release; new request after reset completes normally.
- Address bits [4:0]=0x1F and bits above SRAM_AW+1 set -> ignored, same SRAM words as aligned address.
